mem_port: RTL
=============

# mem_port

Per-core client of the shared main-memory arbiter. Each core owns one instance. It turns a single core memory operation (load, store, lock, unlock) into the arbiter's request/acknowledge handshake, then drives the address, data and strobe for the granted slot. For loads it captures the returned word. It also counts cycles spent waiting for grants.

## Interface
Parameters:
- WAIT_LAT, 1: cycles from the ACCESS cycle to valid `main_mem_dat` (synchronous data RAM); range 1..3.

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- core_req  in  1  operation valid; sampled only in IDLE
- core_op  in  2  0 LOAD, 1 STORE, 2 LOCK, 3 UNLOCK
- core_adr  in  16  word address; bits [9:0] are the lock address for LOCK/UNLOCK
- core_wdat  in  16  store data
- core_busy  out  1  high whenever state != IDLE
- core_done  out  1  one-cycle completion pulse
- core_rdat  out  16  last loaded word; held until next LOAD completes
- main_mem_read_request  out  1  read-slot request
- main_mem_write_request  out  1  write-slot request
- main_mem_ac  in  1  this core's grant bit from the arbiter
- main_mem_read  out  1  read strobe, ACCESS cycle only
- main_mem_write  out  1  write strobe, ACCESS cycle only
- main_mem_read_adr  out  16  latched address
- main_mem_write_adr  out  16  latched address
- main_mem_write_dat  out  16  latched store data
- main_mem_dat  in  16  shared read data bus
- lock_adr  out  10  latched core_adr[9:0]
- lock_en  out  1  lock request
- unlock_en  out  1  unlock request
- lock_ac  in  1  lock/unlock acknowledge
- stall_cnt  out  16  saturating count of grant-wait cycles

## Operation
- States: IDLE, REQ, ACCESS, RDWAIT, LOCK, UNLOCK.
- IDLE:
  - When core_req=1, latch op, adr and wdat into the address and data registers.
  - Go to REQ for LOAD or STORE, LOCK for LOCK, UNLOCK for UNLOCK.
- REQ:
  - Assert read_request (LOAD) or write_request (STORE) as a Moore output.
  - When main_mem_ac=1 is sampled, go to ACCESS.
- ACCESS:
  - Assert main_mem_read or main_mem_write for exactly one cycle; both requests are low.
  - STORE goes to IDLE with core_done pulsed.
  - LOAD goes to RDWAIT.
- RDWAIT:
  - Stay for WAIT_LAT cycles; a 2-bit down-counter tracks them.
  - On the edge ending the last RDWAIT cycle, capture main_mem_dat into core_rdat, go to IDLE and pulse core_done.
- LOCK:
  - Assert lock_en.
  - When lock_ac=1 is sampled, go to IDLE and pulse core_done.
- UNLOCK: same as LOCK, using unlock_en.
- The block never holds the read and write strobes, or lock_en and unlock_en, high at the same time.
- core_req while busy is ignored, not queued. The core must re-present the operation after core_done.
- Address and data outputs always show the latched registers; they are not zeroed between operations.
- stall_cnt:
  - Increments by 1 each cycle in REQ with main_mem_ac=0.
  - Increments by 1 each cycle in LOCK or UNLOCK with lock_ac=0.
  - Saturates at 16'hFFFF; only reset clears it.

## Timing
- Reset value of every output is 0; core_rdat and stall_cnt are also 0.
- Reset assertion forces IDLE and drops requests, strobes and lock enables immediately (asynchronously), including mid-operation.
- core_done:
  - Registered; high during the first IDLE cycle after completion.
  - core_req may be accepted in that same cycle.
- LOAD with an immediate grant: core_req at cycle 0, REQ at c1, ACCESS at c2, RDWAIT at c3 (WAIT_LAT=1), core_done and valid core_rdat at c4.
- STORE with an immediate grant: REQ at c1, ACCESS at c2, core_done at c3.
- LOCK/UNLOCK with an immediate acknowledge: LOCK at c1, core_done at c2.
- The grant is sampled only in REQ. A main_mem_ac pulse in any other state has no effect.

## Structure
- Shared package mem_pkg holds:
  - mem_op_t enum (LOAD, STORE, LOCK, UNLOCK)
  - mem_port_state_t enum
  - ADR_W=16, DAT_W=16, LOCK_ADR_W=10
- Sub-module sat_cnt (16-bit saturating incrementer with enable) implements the stall counter.
- Everything else lives in mem_port.

## Test plan
- LOAD adr 0x0040, memory model returns 0xBEEF, grant in first REQ cycle, WAIT_LAT=1 -> main_mem_read high only at c2 with read_adr 0x0040; core_rdat=0xBEEF and core_done at c4; stall_cnt=0.
- STORE adr 0x0100 wdat 0x1234, grant withheld 5 REQ cycles -> write_request high c1..c6; main_mem_write at c7 with 0x0100/0x1234; core_done at c8; stall_cnt=5.
- LOCK adr 0x03FF, lock_ac low 3 cycles, then UNLOCK with immediate acknowledge -> lock_en high 4 cycles with lock_adr 0x3FF; unlock_en high 1 cycle; two core_done pulses; stall_cnt=3.
- reset driven low while in REQ -> read_request falls within the same cycle, before the next edge; after release: IDLE, core_busy=0, stall_cnt=0, core_rdat=0.
- core_req with op STORE pulsed during a pending LOAD -> ignored; exactly one ACCESS (read); no write strobe ever.
- Grant withheld 70000 cycles -> stall_cnt holds 0xFFFF with no wrap; the grant then completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and widths for the per-core main-memory client.
package mem_pkg;

    localparam int unsigned ADR_W      = 16;
    localparam int unsigned DAT_W      = 16;
    localparam int unsigned LOCK_ADR_W = 10;

    typedef enum logic [1:0] {
        OpLoad   = 2'd0,
        OpStore  = 2'd1,
        OpLock   = 2'd2,
        OpUnlock = 2'd3
    } mem_op_t;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StReq    = 3'd1,
        StAccess = 3'd2,
        StRdwait = 3'd3,
        StLock   = 3'd4,
        StUnlock = 3'd5
    } mem_port_state_t;

    // First state entered from IDLE for a newly accepted operation.
    function automatic mem_port_state_t op_entry_state(input mem_op_t op);
        case (op)
            OpLock:   return StLock;
            OpUnlock: return StUnlock;
            default:  return StReq;
        endcase
    endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with enable; sticks at all-ones until reset.
module sat_cnt #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;

    // Count up while enabled, holding at the maximum value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mem_port.sv
// Per-core client of the shared main-memory arbiter: turns one core operation
// into the request/grant handshake, drives the granted slot and counts stalls.
module mem_port
    import mem_pkg::*;
#(
    parameter int unsigned WAIT_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_req,
    input  logic [1:0]            core_op,
    input  logic [ADR_W-1:0]      core_adr,
    input  logic [DAT_W-1:0]      core_wdat,
    output logic                  core_busy,
    output logic                  core_done,
    output logic [DAT_W-1:0]      core_rdat,
    output logic                  main_mem_read_request,
    output logic                  main_mem_write_request,
    input  logic                  main_mem_ac,
    output logic                  main_mem_read,
    output logic                  main_mem_write,
    output logic [ADR_W-1:0]      main_mem_read_adr,
    output logic [ADR_W-1:0]      main_mem_write_adr,
    output logic [DAT_W-1:0]      main_mem_write_dat,
    input  logic [DAT_W-1:0]      main_mem_dat,
    output logic [LOCK_ADR_W-1:0] lock_adr,
    output logic                  lock_en,
    output logic                  unlock_en,
    input  logic                  lock_ac,
    output logic [15:0]           stall_cnt
);

    // RDWAIT counter reload; the last RDWAIT cycle is the one with a zero count.
    localparam logic [1:0] WaitInit = 2'(WAIT_LAT - 1);

    mem_port_state_t state_q, state_d;
    mem_op_t         op_q, op_d;
    mem_op_t         core_op_e;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [DAT_W-1:0] wdat_q, wdat_d;
    logic [DAT_W-1:0] rdat_q, rdat_d;
    logic [1:0]       wait_q, wait_d;
    logic             done_q, done_d;
    logic             stall_en;

    assign core_op_e = mem_op_t'(core_op);

    // State and datapath registers; reset returns to IDLE mid-operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            op_q    <= OpLoad;
            adr_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            wait_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            wait_q  <= wait_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; requests arriving outside IDLE are dropped, not queued.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        wait_d  = wait_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (core_req) begin
                    op_d    = core_op_e;
                    adr_d   = core_adr;
                    wdat_d  = core_wdat;
                    state_d = op_entry_state(core_op_e);
                end
            end
            StReq: begin
                if (main_mem_ac) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (op_q == OpStore) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    state_d = StRdwait;
                    wait_d  = WaitInit;
                end
            end
            StRdwait: begin
                if (wait_q == 2'd0) begin
                    rdat_d  = main_mem_dat;
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            StLock, StUnlock: begin
                if (lock_ac) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Moore outputs decoded from state; strobes and enables are mutually exclusive.
    always_comb begin
        main_mem_read_request  = 1'b0;
        main_mem_write_request = 1'b0;
        main_mem_read          = 1'b0;
        main_mem_write         = 1'b0;
        lock_en                = 1'b0;
        unlock_en              = 1'b0;
        stall_en               = 1'b0;
        unique case (state_q)
            StReq: begin
                main_mem_read_request  = (op_q == OpLoad);
                main_mem_write_request = (op_q == OpStore);
                stall_en               = !main_mem_ac;
            end
            StAccess: begin
                main_mem_read  = (op_q == OpLoad);
                main_mem_write = (op_q == OpStore);
            end
            StLock: begin
                lock_en  = 1'b1;
                stall_en = !lock_ac;
            end
            StUnlock: begin
                unlock_en = 1'b1;
                stall_en  = !lock_ac;
            end
            default: begin
            end
        endcase
    end

    sat_cnt #(
        .WIDTH (16)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (stall_en),
        .cnt   (stall_cnt)
    );

    assign core_busy          = (state_q != StIdle);
    assign core_done          = done_q;
    assign core_rdat          = rdat_q;
    assign main_mem_read_adr  = adr_q;
    assign main_mem_write_adr = adr_q;
    assign main_mem_write_dat = wdat_q;
    assign lock_adr           = adr_q[LOCK_ADR_W-1:0];

endmodule
